pc_bpred: RTL and testbench
===========================

// Module: pc_bpred
// PURPOSE
//  Next-generation fetch PC generator with a direct-mapped branch target buffer (BTB)
//  and 2-bit saturating direction counters. Feeds the IF stage.
//  - Each cycle: predicts the next PC from the current pc_out.
//  - From EX: accepts branch-resolution updates and misprediction redirects.
// PARAMETERS
//  XLEN          32  PC width in bits.
//  BTB_INDEX_LEN 6   log2 of the BTB entry count (64 entries).
//  RESET_PC      0   pc_out value while in reset and after reset.
// PORTS
//  clk_in            in   1     Clock; all state updates on the rising edge.
//  rst_in            in   1     Reset; asynchronous, active-low.
//  rdy_in            in   1     Global ready; 0 freezes all state.
//  stall_in          in   1     PC-stage stall from stall control; 1 = hold pc_out.
//  ex_redirect_in    in   1     EX detected a mispredict; load ex_redirect_addr_in.
//  ex_redirect_addr_in in XLEN  Correct next PC after the mispredict.
//  ex_upd_valid_in   in   1     A resolved branch/jump is presented for training.
//  ex_upd_pc_in      in   XLEN  PC of the resolved branch.
//  ex_upd_taken_in   in   1     Actual direction of the resolved branch.
//  ex_upd_target_in  in   XLEN  Actual target of the resolved branch.
//  pc_out            out  XLEN  Current fetch PC (registered).
//  pred_taken_out    out  1     Combinational: pc_out is predicted taken.
//  pred_target_out   out  XLEN  Combinational: predicted next PC (carried down the pipe to EX).
// BEHAVIOUR
//  - Reset (rst_in=0, asynchronous):
//    - pc_out = RESET_PC.
//    - All BTB valid bits = 0; all counters = 2'b01 (weakly not-taken).
//    - pred_taken_out = 0; pred_target_out = RESET_PC + 4.
//  - Lookup (combinational):
//    - idx = pc_out[BTB_INDEX_LEN+1:2]; tag = pc_out[XLEN-1:BTB_INDEX_LEN+2].
//    - hit = valid[idx] & (tag_mem[idx] == tag).
//    - pred_taken_out = hit & ctr[idx][1].
//    - pred_target_out = pred_taken_out ? tgt_mem[idx] : pc_out + 4.
//    - pc_out + 4 wraps modulo 2^XLEN.
//  - PC register update, priority order:
//    1. rdy_in=0 -> hold everything; BTB updates are also dropped.
//    2. ex_redirect_in -> pc_out <= {ex_redirect_addr_in[XLEN-1:2], 2'b00}.
//       Applied even when stall_in=1.
//    3. stall_in -> hold pc_out.
//    4. Otherwise -> pc_out <= pred_target_out.
//  - BTB training (ex_upd_valid_in & rdy_in), indexed/tagged by ex_upd_pc_in:
//    - Tag hit: ctr saturating +1 if taken, -1 if not (bounds 2'b00 / 2'b11).
//      If taken, also tgt <= ex_upd_target_in.
//    - Tag miss and taken: allocate/replace entry:
//      valid=1, tag, tgt written, ctr=2'b10.
//    - Tag miss and not-taken: no change.
//  - Same-cycle update and lookup of the same index: lookup uses the pre-edge contents
//    (write-after-read). The new value is visible the next cycle.
//  - Training is independent of redirect/stall; both may occur in one cycle.
//  - Latency:
//    - Redirect: 1 cycle (pc_out shows the new address on the next edge).
//    - Training: affects predictions from the next cycle onward.
//  - Reset asserted mid-operation clears all state immediately; no partial writes survive.
// CONFIGURATION
//  - PC_BPRED_BTB_EN defined: BTB and counters built as above.
//  - PC_BPRED_BTB_EN undefined:
//    - No storage is built; ex_upd_* are ignored.
//    - pred_taken_out = 0; pred_target_out = pc_out + 4.
//    - Redirect, stall, rdy_in and reset behave identically.
// TESTING
//  1. Reset with RESET_PC=0, stall_in=0: pc_out sequence 0, 4, 8, 12; pred_taken_out=0.
//  2. Train pc=0x10 taken -> 0x80:
//     - One update: ctr=2'b10. Next fetch of 0x10 gives pred_taken_out=1, next pc_out=0x80.
//     - Two not-taken updates: prediction falls back to 0x14.
//  3. Redirect 0x203 with stall_in=1: next pc_out=0x200. With rdy_in=0 instead, pc_out holds.
//  4. Aliasing: trained entry for 0x10, lookup at 0x10+(4<<BTB_INDEX_LEN):
//     tag miss -> predicts pc+4.
//  5. Saturation and wrap:
//     - Five taken updates keep ctr=2'b11; one not-taken still predicts taken.
//     - pc_out=0xFFFFFFFC advances to 0.
//  6. PC_BPRED_BTB_EN undefined:
//     - After test 2 training, 0x10 still predicts 0x14.
//     - Assert rst_in=0 asynchronously between edges: pc_out=RESET_PC at once.

Source files
------------

// File: rtl/pc_bpred.sv
// Fetch PC generator with an optional direct-mapped BTB and 2-bit direction counters.
// Optional feature macro: PC_BPRED_BTB_EN (defined -> BTB and counters are built;
// undefined -> the PC simply steps by 4 unless redirected).
module pc_bpred #(
  parameter int XLEN = 32,
  parameter int BTB_INDEX_LEN = 6,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  input  logic            stall_in,
  input  logic            ex_redirect_in,
  input  logic [XLEN-1:0] ex_redirect_addr_in,
  input  logic            ex_upd_valid_in,
  input  logic [XLEN-1:0] ex_upd_pc_in,
  input  logic            ex_upd_taken_in,
  input  logic [XLEN-1:0] ex_upd_target_in,
  output logic [XLEN-1:0] pc_out,
  output logic            pred_taken_out,
  output logic [XLEN-1:0] pred_target_out
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;

  // Sequential fetch address; wraps naturally modulo 2^XLEN.
  assign pc_plus4 = pc + PC_STEP;

`ifdef PC_BPRED_BTB_EN
  localparam int TAG_LEN = XLEN - BTB_INDEX_LEN - 2;
  localparam int ENTRIES = 1 << BTB_INDEX_LEN;

  logic [ENTRIES-1:0]       valid;
  logic [1:0]               ctr     [ENTRIES];
  logic [TAG_LEN-1:0]       tag_mem [ENTRIES];
  logic [XLEN-1:0]          tgt_mem [ENTRIES];

  logic [BTB_INDEX_LEN-1:0] look_idx;
  logic [TAG_LEN-1:0]       look_tag;
  logic                     look_hit;
  logic [BTB_INDEX_LEN-1:0] upd_idx;
  logic [TAG_LEN-1:0]       upd_tag;
  logic                     upd_hit;
  logic                     upd_en;
  logic                     unused_bits;

  assign look_idx = pc[BTB_INDEX_LEN+1:2];
  assign look_tag = pc[XLEN-1:BTB_INDEX_LEN+2];
  assign look_hit = valid[look_idx] && (tag_mem[look_idx] == look_tag);

  assign upd_idx  = ex_upd_pc_in[BTB_INDEX_LEN+1:2];
  assign upd_tag  = ex_upd_pc_in[XLEN-1:BTB_INDEX_LEN+2];
  assign upd_hit  = valid[upd_idx] && (tag_mem[upd_idx] == upd_tag);
  assign upd_en   = rdy_in && ex_upd_valid_in;

  assign unused_bits = ^{ex_redirect_addr_in[1:0], ex_upd_pc_in[1:0]};

  // Combinational prediction from the pre-edge BTB contents.
  always_comb begin
    pred_taken  = look_hit && ctr[look_idx][1];
    pred_target = pred_taken ? tgt_mem[look_idx] : pc_plus4;
  end

  // Valid bits and direction counters: cleared by reset, trained by resolved branches.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr[i] <= 2'b01;
      end
    end else if (upd_en) begin
      if (upd_hit) begin
        if (ex_upd_taken_in) begin
          if (ctr[upd_idx] != 2'b11) ctr[upd_idx] <= ctr[upd_idx] + 2'b01;
        end else begin
          if (ctr[upd_idx] != 2'b00) ctr[upd_idx] <= ctr[upd_idx] - 2'b01;
        end
      end else if (ex_upd_taken_in) begin
        valid[upd_idx] <= 1'b1;
        ctr[upd_idx]   <= 2'b10;
      end
    end
  end

  // Tag/target storage; only meaningful behind a valid bit, so no reset is needed.
  always_ff @(posedge clk_in) begin
    if (rst_in && upd_en && ex_upd_taken_in) begin
      tag_mem[upd_idx] <= upd_tag;
      tgt_mem[upd_idx] <= ex_upd_target_in;
    end
  end
`else
  logic unused_upd;

  assign unused_upd = ^{ex_redirect_addr_in[1:0], ex_upd_valid_in, ex_upd_pc_in,
                        ex_upd_taken_in, ex_upd_target_in};

  // Without a BTB every fetch is predicted sequential.
  always_comb begin
    pred_taken  = 1'b0;
    pred_target = pc_plus4;
  end
`endif

  // PC register: global ready gates everything, redirect beats stall.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pc <= RESET_PC;
    end else if (rdy_in) begin
      if (ex_redirect_in) begin
        pc <= {ex_redirect_addr_in[XLEN-1:2], 2'b00};
      end else if (!stall_in) begin
        pc <= pred_target;
      end
    end
  end

  assign pc_out          = pc;
  assign pred_taken_out  = pred_taken;
  assign pred_target_out = pred_target;

endmodule

// File: tb/tb_pc_bpred.sv
// Self-checking bench for pc_bpred: directed steps, reference model and a scoreboard
// of expected next-PC values. Follows PC_BPRED_BTB_EN like the design does.
module tb_pc_bpred;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        stall_in;
  logic        ex_redirect_in;
  logic [31:0] ex_redirect_addr_in;
  logic        ex_upd_valid_in;
  logic [31:0] ex_upd_pc_in;
  logic        ex_upd_taken_in;
  logic [31:0] ex_upd_target_in;
  logic [31:0] pc_out;
  logic        pred_taken_out;
  logic [31:0] pred_target_out;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef PC_BPRED_BTB_EN
  localparam logic        BTB_ON      = 1'b1;
  localparam logic [31:0] T2_NEXT     = 32'h80;
  localparam logic [31:0] T5_TARGET   = 32'h100;
`else
  localparam logic        BTB_ON      = 1'b0;
  localparam logic [31:0] T2_NEXT     = 32'h14;
  localparam logic [31:0] T5_TARGET   = 32'h44;
`endif

  // Reference model state
  logic        m_valid [64];
  logic [23:0] m_tag   [64];
  logic [31:0] m_tgt   [64];
  logic [1:0]  m_ctr   [64];
  logic [31:0] m_pc;
  logic [31:0] exp_q [$];

  pc_bpred dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .stall_in(stall_in),
    .ex_redirect_in(ex_redirect_in), .ex_redirect_addr_in(ex_redirect_addr_in),
    .ex_upd_valid_in(ex_upd_valid_in), .ex_upd_pc_in(ex_upd_pc_in),
    .ex_upd_taken_in(ex_upd_taken_in), .ex_upd_target_in(ex_upd_target_in),
    .pc_out(pc_out), .pred_taken_out(pred_taken_out), .pred_target_out(pred_target_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 2'b01;
      m_tag[i]   = '0;
      m_tgt[i]   = '0;
    end
  endtask

  function automatic logic model_taken(input logic [31:0] pc);
    int i;
    i = int'(pc[7:2]);
    return BTB_ON && m_valid[i] && (m_tag[i] == pc[31:8]) && m_ctr[i][1];
  endfunction

  function automatic logic [31:0] model_target(input logic [31:0] pc);
    return model_taken(pc) ? m_tgt[int'(pc[7:2])] : pc + 32'd4;
  endfunction

  task automatic model_train(input logic [31:0] upc, input logic tk, input logic [31:0] tgt);
    int  i;
    logic hit;
    i   = int'(upc[7:2]);
    hit = m_valid[i] && (m_tag[i] == upc[31:8]);
    if (hit) begin
      if (tk) begin
        m_ctr[i] = (m_ctr[i] == 2'b11) ? 2'b11 : m_ctr[i] + 2'b01;
        m_tgt[i] = tgt;
      end else begin
        m_ctr[i] = (m_ctr[i] == 2'b00) ? 2'b00 : m_ctr[i] - 2'b01;
      end
    end else if (tk) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = upc[31:8];
      m_tgt[i]   = tgt;
      m_ctr[i]   = 2'b10;
    end
  endtask

  // One clock: drive at posedge+1, check combinational outputs at negedge,
  // push the expected next PC, then pop and compare it at the next posedge+1.
  task automatic do_cycle(input logic rdy, input logic stall, input logic redir,
                          input logic [31:0] raddr, input logic uv, input logic [31:0] upc,
                          input logic utk, input logic [31:0] utgt);
    logic [31:0] nxt;
    logic [31:0] got;
    rdy_in = rdy; stall_in = stall; ex_redirect_in = redir; ex_redirect_addr_in = raddr;
    ex_upd_valid_in = uv; ex_upd_pc_in = upc; ex_upd_taken_in = utk; ex_upd_target_in = utgt;
    @(negedge clk_in);
    check("pc_now", pc_out, m_pc);
    check("pred_taken", {31'd0, pred_taken_out}, {31'd0, model_taken(m_pc)});
    check("pred_target", pred_target_out, model_target(m_pc));
    nxt = m_pc;
    if (rdy) begin
      if (redir) nxt = {raddr[31:2], 2'b00};
      else if (!stall) nxt = model_target(m_pc);
      if (uv && BTB_ON) model_train(upc, utk, utgt);
    end
    exp_q.push_back(nxt);
    @(posedge clk_in);
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      got = exp_q.pop_front();
      check("pc_next", pc_out, got);
      m_pc = got;
    end
    ex_redirect_in = 1'b0; ex_upd_valid_in = 1'b0;
  endtask

  task automatic idle();
    do_cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic redirect(input logic [31:0] a);
    do_cycle(1'b1, 1'b0, 1'b1, a, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic train(input logic [31:0] upc, input logic tk, input logic [31:0] tgt);
    do_cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, upc, tk, tgt);
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; stall_in = 1'b0; ex_redirect_in = 1'b0;
    ex_redirect_addr_in = '0; ex_upd_valid_in = 1'b0; ex_upd_pc_in = '0;
    ex_upd_taken_in = 1'b0; ex_upd_target_in = '0;
    model_reset();

    // Test 1: reset state and sequential fetch
    #2;
    check("rst_pc", pc_out, 32'h0);
    check("rst_taken", {31'd0, pred_taken_out}, 32'd0);
    check("rst_target", pred_target_out, 32'h4);
    @(posedge clk_in); #1;
    check("rst_hold_pc", pc_out, 32'h0);
    rst_in = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      idle();
      check("t1_seq", pc_out, 32'(k * 4));
    end
    check("t1_taken", {31'd0, pred_taken_out}, 32'd0);

    // Test 2: train 0x10 taken -> 0x80, then two not-taken
    do_cycle(1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 32'h10, 1'b1, 32'h80);
    check("t2_pc", pc_out, 32'h10);
    check("t2_pred_taken", {31'd0, pred_taken_out}, {31'd0, BTB_ON});
    idle();
    check("t2_taken_next", pc_out, T2_NEXT);
    train(32'h10, 1'b0, 32'h0);
    train(32'h10, 1'b0, 32'h0);
    redirect(32'h10);
    check("t2_fallback", pred_target_out, 32'h14);

    // Test 3: redirect beats stall; rdy_in=0 freezes PC and drops training
    do_cycle(1'b1, 1'b1, 1'b1, 32'h203, 1'b0, 32'h0, 1'b0, 32'h0);
    check("t3_redirect_stall", pc_out, 32'h200);
    do_cycle(1'b0, 1'b0, 1'b1, 32'h303, 1'b1, 32'h30, 1'b1, 32'h500);
    check("t3_rdy_hold", pc_out, 32'h200);
    redirect(32'h30);
    check("t3_drop_upd", pred_target_out, 32'h34);

    // Test 4: aliasing at 0x10 + (4 << 6)
    train(32'h10, 1'b1, 32'h80);
    train(32'h10, 1'b1, 32'h80);
    redirect(32'h10);
    check("t4_trained", pred_target_out, T2_NEXT);
    redirect(32'h110);
    check("t4_alias_taken", {31'd0, pred_taken_out}, 32'd0);
    check("t4_alias_target", pred_target_out, 32'h114);

    // Same-cycle training and lookup of the current PC: old contents seen first
    redirect(32'h20);
    train(32'h20, 1'b1, 32'h90);
    check("war_after", {31'd0, pred_taken_out}, {31'd0, BTB_ON});

    // Test 5: saturation and wrap
    for (int k = 0; k < 5; k++) train(32'h40, 1'b1, 32'h100);
    train(32'h40, 1'b0, 32'h0);
    redirect(32'h40);
    check("t5_sat_target", pred_target_out, T5_TARGET);
    redirect(32'hFFFF_FFFF);
    check("t5_top_pc", pc_out, 32'hFFFF_FFFC);
    check("t5_wrap_target", pred_target_out, 32'h0);
    idle();
    check("t5_wrap_pc", pc_out, 32'h0);

    // Test 6: asynchronous reset between edges clears PC and BTB
    redirect(32'h10);
    idle();
    @(negedge clk_in); #2;
    rst_in = 1'b0;
    #1;
    check("t6_async_pc", pc_out, 32'h0);
    check("t6_async_taken", {31'd0, pred_taken_out}, 32'd0);
    check("t6_async_target", pred_target_out, 32'h4);
    model_reset();
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    redirect(32'h10);
    check("t6_btb_cleared", pred_target_out, 32'h14);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
